wide_add_seq: RTL

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

---
 rtl/wide_add_pkg.sv | 4 +
 rtl/adder_n_cin.sv | 17 +
 rtl/full_adder.sv | 11 +
 rtl/wide_add_seq.sv | 77 +++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
// wide_add_pkg: FSM state encoding shared by wide_add_seq.
package wide_add_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/adder_n_cin.sv
// adder_n_cin: N-bit ripple-carry adder with carry-in, built from full_adder cells.
module adder_n_cin #(
    parameter int N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    logic [N:0] c;
    assign c[0] = ci;
    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (.x(x[i]), .y(y[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
    end
    assign co = c[N];
endmodule

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: W-bit adder that reuses one N-bit slice over WORDS cycles.
// Define WIDE_ADD_SUB_EN to add a sub port selecting a - b.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
`ifdef WIDE_ADD_SUB_EN
    input  logic                 sub,
`endif
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    output logic                 busy,
    output logic                 done,
    output logic [N*WORDS-1:0]   sum,
    output logic                 cout
);
    localparam int W  = N * WORDS;
    localparam int IW = $clog2(WORDS);

    state_t         state, nxt;
    logic [IW-1:0]  idx;
    logic [W-1:0]   a_r, b_r;
    logic           carry, sub_r, sub_in, co, last, accept;
    logic [N-1:0]   xb, s;

`ifdef WIDE_ADD_SUB_EN
    assign sub_in = sub;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sub_r <= 1'b0;
        else if (accept) sub_r <= sub;
`else
    assign sub_in = 1'b0;
    assign sub_r  = 1'b0;
`endif

    assign last   = idx == IW'(WORDS - 1);
    assign accept = state == IDLE && start;
    // Subtraction is a + ~b + 1: invert b per slice, carry seeded with 1
    assign xb     = sub_r ? ~b_r[idx*N +: N] : b_r[idx*N +: N];

    adder_n_cin #(.N(N)) u_slice (.x(a_r[idx*N +: N]), .y(xb), .ci(carry), .s(s), .co(co));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt  = accept ? RUN : (state == RUN && last) ? DONE : state == DONE ? IDLE : state;
        busy = state == RUN;
        done = state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
        end else if (accept) begin
            a_r   <= a;
            b_r   <= b;
            idx   <= '0;
            carry <= sub_in;
        end else if (state == RUN) begin
            sum[idx*N +: N] <= s;
            carry           <= co;
            if (last) cout <= co;
            else idx <= idx + IW'(1);
        end
endmodule
